// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared data width, shift-type codes and FSM state encoding
//               for the iterative operand-2 shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : One combinational shift/rotate step of k positions (k may be
//               0) plus the last bit shifted out.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [DATA_W-1:0] i_acc,
    input  logic [1:0]        i_shift_type,
    input  logic [CNT_W-1:0]  i_k,
    output logic [DATA_W-1:0] o_shifted,
    output logic              o_carry
);

    logic [DATA_W-1:0] w_lsl;
    logic [DATA_W-1:0] w_lsr;
    logic [DATA_W-1:0] w_asr;
    logic [DATA_W-1:0] w_ror;
    logic [CNT_W:0]    w_rot_l;
    logic [CNT_W-1:0]  w_lsl_idx;
    logic [CNT_W-1:0]  w_rsh_idx;

    assign w_lsl   = i_acc << i_k;
    assign w_lsr   = i_acc >> i_k;
    assign w_asr   = $signed(i_acc) >>> i_k;
    // Left part of the rotate; a width-sized shift yields zero when k is 0.
    assign w_rot_l = (CNT_W+1)'(DATA_W) - {1'b0, i_k};
    assign w_ror   = w_lsr | (i_acc << w_rot_l);

    // Bit positions of the last bit out: 32-k (mod 32) for LSL, k-1 otherwise.
    assign w_lsl_idx = ~i_k + CNT_W'(1);
    assign w_rsh_idx = i_k - CNT_W'(1);

    always_comb begin
        o_shifted = i_acc;
        o_carry   = 1'b0;
        case (i_shift_type)
            LSL: begin
                o_shifted = w_lsl;
                o_carry   = i_acc[w_lsl_idx];
            end
            LSR: begin
                o_shifted = w_lsr;
                o_carry   = i_acc[w_rsh_idx];
            end
            ASR: begin
                o_shifted = w_asr;
                o_carry   = i_acc[w_rsh_idx];
            end
            default: begin
                o_shifted = w_ror;
                o_carry   = i_acc[w_rsh_idx];
            end
        endcase
        if (i_k == '0) begin
            o_carry = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle operand-2 shifter applying at most STEP positions
//               per clock, with start/done handshake and busy for stalling.
//               Optional macro SHIFT_CARRY_OUT_EN enables the carry_out path.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              mem_en,
    input  logic              imm,
    input  logic [11:0]       shifter_operand,
    input  logic [DATA_W-1:0] val_Rm,
    input  logic              carry_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    localparam logic [CNT_W-1:0] c_step = CNT_W'(STEP);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic [1:0]        r_type;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_load_acc;
    logic [1:0]        w_load_type;
    logic [CNT_W-1:0]  w_load_cnt;
    logic [CNT_W-1:0]  w_k;
    logic [DATA_W-1:0] w_step_out;
    logic              w_step_carry;
    logic              w_accept;
    logic              w_step_en;
    logic              w_last_step;

    // Operand decode; mem_en takes priority over the rotated immediate.
    always_comb begin
        w_load_acc  = val_Rm;
        w_load_type = shifter_operand[6:5];
        w_load_cnt  = CNT_W'(shifter_operand[11:7]);
        if (mem_en) begin
            w_load_acc  = {{20{shifter_operand[11]}}, shifter_operand};
            w_load_type = LSL;
            w_load_cnt  = '0;
        end else if (imm) begin
            w_load_acc  = {24'd0, shifter_operand[7:0]};
            w_load_type = ROR;
            w_load_cnt  = CNT_W'({shifter_operand[11:8], 1'b0});
        end
    end

    assign w_accept    = (r_state == IDLE) && start && !flush;
    assign w_step_en   = (r_state == SHIFT) && !flush;
    assign w_k         = (r_cnt < c_step) ? r_cnt : c_step;
    assign w_last_step = (r_cnt == w_k);

    shift_step #(
        .CNT_W (CNT_W)
    ) u_step (
        .i_acc        (r_acc),
        .i_shift_type (r_type),
        .i_k          (w_k),
        .o_shifted    (w_step_out),
        .o_carry      (w_step_carry)
    );

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next_state = (w_load_cnt == '0) ? DONE : SHIFT;
                SHIFT:   if (w_last_step) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // result moves only on a zero-count load or on the final shift step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_type   <= LSL;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc  <= w_load_acc;
            r_type <= w_load_type;
            r_cnt  <= w_load_cnt;
            if (w_load_cnt == '0) begin
                r_result <= w_load_acc;
            end
        end else if (w_step_en) begin
            r_acc <= w_step_out;
            r_cnt <= r_cnt - w_k;
            if (w_last_step) begin
                r_result <= w_step_out;
            end
        end
    end

`ifdef SHIFT_CARRY_OUT_EN
    logic r_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (w_accept && (w_load_cnt == '0)) begin
            r_carry <= carry_in;
        end else if (w_step_en) begin
            r_carry <= w_step_carry;
        end
    end

    assign carry_out = r_carry;
`else
    logic w_unused;

    assign w_unused  = carry_in ^ w_step_carry;
    assign carry_out = 1'b0;
`endif

    assign ready  = (r_state == IDLE);
    assign busy   = (r_state == SHIFT) || (r_state == DONE);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed self-checking bench; one instance with STEP=1 and
//               one with STEP=4 share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

`ifdef SHIFT_CARRY_OUT_EN
    localparam logic c_carry_en = 1'b1;
`else
    localparam logic c_carry_en = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic        mem_en;
    logic        imm;
    logic [11:0] op;
    logic [31:0] rm;
    logic        carry_in;

    logic        ready1, busy1, done1, cout1;
    logic [31:0] result1;
    logic        ready4, busy4, done4, cout4;
    logic [31:0] result4;

    int n_pass  = 0;
    int n_total = 0;

    shift_sequencer #(.STEP(1), .CNT_W(5)) u_dut (
        .clk (clk), .rst (rst), .start (start), .flush (flush),
        .mem_en (mem_en), .imm (imm), .shifter_operand (op), .val_Rm (rm),
        .carry_in (carry_in), .ready (ready1), .busy (busy1), .done (done1),
        .result (result1), .carry_out (cout1)
    );

    shift_sequencer #(.STEP(4), .CNT_W(5)) u_dut4 (
        .clk (clk), .rst (rst), .start (start), .flush (flush),
        .mem_en (mem_en), .imm (imm), .shifter_operand (op), .val_Rm (rm),
        .carry_in (carry_in), .ready (ready4), .busy (busy4), .done (done4),
        .result (result4), .carry_out (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start and records the done cycle/result of both instances.
    task automatic do_op(input logic me, input logic im, input logic [11:0] o,
                         input logic [31:0] r, output int lat1, output int lat4,
                         output int busyc1, output logic [31:0] res1,
                         output logic [31:0] res4);
        mem_en = me; imm = im; op = o; rm = r; start = 1'b1;
        tick();
        start = 1'b0; mem_en = 1'b0; imm = 1'b0;
        lat1 = -1; lat4 = -1; busyc1 = 0; res1 = '0; res4 = '0;
        for (int c = 1; c <= 60 && (lat1 < 0 || lat4 < 0); c++) begin
            if (busy1) busyc1++;
            if (done1 && lat1 < 0) begin lat1 = c; res1 = result1; end
            if (done4 && lat4 < 0) begin lat4 = c; res4 = result4; end
            tick();
        end
        for (int c = 0; c < 4 && !(ready1 && ready4); c++) tick();
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (ready1 !== 1'b1) $display("FAIL reset_ready got %b want 1", ready1); else n_pass++;
        n_total++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else n_pass++;
        n_total++; if (done1 !== 1'b0) $display("FAIL reset_done got %b want 0", done1); else n_pass++;
        n_total++; if (result1 !== 32'h0) $display("FAIL reset_result got %h want 0", result1); else n_pass++;
        n_total++; if (cout1 !== 1'b0) $display("FAIL reset_carry got %b want 0", cout1); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsl();
        int l1, l4, b1; logic [31:0] r1, r4;
        do_op(1'b0, 1'b0, 12'h200, 32'h0000_0001, l1, l4, b1, r1, r4);
        n_total++; if (l1 !== 5) $display("FAIL lsl4_lat1 got %0d want 5", l1); else n_pass++;
        n_total++; if (r1 !== 32'h10) $display("FAIL lsl4_res1 got %h want 00000010", r1); else n_pass++;
        n_total++; if (b1 !== 5) $display("FAIL lsl4_busy_cycles got %0d want 5", b1); else n_pass++;
        n_total++; if (l4 !== 2) $display("FAIL lsl4_lat4 got %0d want 2", l4); else n_pass++;
        n_total++; if (r4 !== 32'h10) $display("FAIL lsl4_res4 got %h want 00000010", r4); else n_pass++;
    endtask

    task automatic test_imm_ror();
        int l1, l4, b1; logic [31:0] r1, r4;
        do_op(1'b0, 1'b1, 12'h1FF, 32'hFFFF_FFFF, l1, l4, b1, r1, r4);
        n_total++; if (l1 !== 3) $display("FAIL imm_lat1 got %0d want 3", l1); else n_pass++;
        n_total++; if (r1 !== 32'hC000_003F) $display("FAIL imm_res1 got %h want c000003f", r1); else n_pass++;
        n_total++; if (l4 !== 2) $display("FAIL imm_lat4 got %0d want 2", l4); else n_pass++;
        n_total++; if (r4 !== 32'hC000_003F) $display("FAIL imm_res4 got %h want c000003f", r4); else n_pass++;
    endtask

    task automatic test_asr31();
        int l1, l4, b1; logic [31:0] r1, r4;
        do_op(1'b0, 1'b0, 12'hFC0, 32'h8000_0000, l1, l4, b1, r1, r4);
        n_total++; if (l1 !== 32) $display("FAIL asr31_lat1 got %0d want 32", l1); else n_pass++;
        n_total++; if (l4 !== 9) $display("FAIL asr31_lat4 got %0d want 9", l4); else n_pass++;
        n_total++; if (r1 !== 32'hFFFF_FFFF) $display("FAIL asr31_res1 got %h want ffffffff", r1); else n_pass++;
        n_total++; if (r4 !== 32'hFFFF_FFFF) $display("FAIL asr31_res4 got %h want ffffffff", r4); else n_pass++;
    endtask

    task automatic test_zero_count();
        int l1, l4, b1; logic [31:0] r1, r4;
        do_op(1'b0, 1'b0, 12'h020, 32'hDEAD_BEEF, l1, l4, b1, r1, r4);
        n_total++; if (l1 !== 1) $display("FAIL lsr0_lat got %0d want 1", l1); else n_pass++;
        n_total++; if (r1 !== 32'hDEAD_BEEF) $display("FAIL lsr0_res got %h want deadbeef", r1); else n_pass++;
    endtask

    task automatic test_mem();
        int l1, l4, b1; logic [31:0] r1, r4;
        do_op(1'b1, 1'b0, 12'h800, 32'h1234_5678, l1, l4, b1, r1, r4);
        n_total++; if (l1 !== 1) $display("FAIL mem_neg_lat got %0d want 1", l1); else n_pass++;
        n_total++; if (r1 !== 32'hFFFF_F800) $display("FAIL mem_neg_res got %h want fffff800", r1); else n_pass++;
        n_total++; if (l4 !== 1) $display("FAIL mem_neg_lat4 got %0d want 1", l4); else n_pass++;
        do_op(1'b1, 1'b1, 12'h7FF, 32'h1234_5678, l1, l4, b1, r1, r4);
        n_total++; if (l1 !== 1) $display("FAIL mem_pos_lat got %0d want 1", l1); else n_pass++;
        n_total++; if (r1 !== 32'h0000_07FF) $display("FAIL mem_pos_res got %h want 000007ff", r1); else n_pass++;
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        rm = 32'h1234_5678; op = 12'h420; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (done1 || done4) seen++;
            if (c == 2) flush = 1'b1;
            if (c == 3) begin
                n_total++; if (ready1 !== 1'b1) $display("FAIL flush_idle got ready=%b want 1", ready1); else n_pass++;
                n_total++; if (busy4 !== 1'b0) $display("FAIL flush_idle4 got busy=%b want 0", busy4); else n_pass++;
            end
            tick();
            flush = 1'b0;
        end
        n_total++; if (seen !== 0) $display("FAIL flush_no_done got %0d pulses want 0", seen); else n_pass++;
        n_total++; if (result1 !== 32'h0000_07FF) $display("FAIL flush_result got %h want 000007ff", result1); else n_pass++;
    endtask

    task automatic test_busy_start();
        int pulses, lat;
        logic [31:0] res;
        pulses = 0; lat = -1; res = '0;
        rm = 32'h0000_0001; op = 12'h200; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (done1) begin pulses++; if (lat < 0) begin lat = c; res = result1; end end
            if (c == 2) begin start = 1'b1; mem_en = 1'b1; op = 12'h123; end
            if (c == 3) begin start = 1'b0; mem_en = 1'b0; end
            tick();
        end
        n_total++; if (lat !== 5) $display("FAIL busy_start_lat got %0d want 5", lat); else n_pass++;
        n_total++; if (pulses !== 1) $display("FAIL busy_start_pulses got %0d want 1", pulses); else n_pass++;
        n_total++; if (res !== 32'h10) $display("FAIL busy_start_res got %h want 00000010", res); else n_pass++;
    endtask

    task automatic test_start_flush();
        int seen;
        seen = 0;
        start = 1'b1; flush = 1'b1; mem_en = 1'b1; op = 12'h555;
        tick();
        start = 1'b0; flush = 1'b0; mem_en = 1'b0;
        n_total++; if (busy1 !== 1'b0) $display("FAIL start_flush_busy got %b want 0", busy1); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (done1 || done4) seen++;
            tick();
        end
        n_total++; if (seen !== 0) $display("FAIL start_flush_done got %0d pulses want 0", seen); else n_pass++;
        n_total++; if (result1 !== 32'h10) $display("FAIL start_flush_result got %h want 00000010", result1); else n_pass++;
    endtask

    task automatic test_carry();
        int l1, l4, b1; logic [31:0] r1, r4;
        carry_in = 1'b0;
        do_op(1'b0, 1'b0, 12'h0A0, 32'h0000_0003, l1, l4, b1, r1, r4);
        n_total++; if (r1 !== 32'h1) $display("FAIL lsr1_res got %h want 00000001", r1); else n_pass++;
        n_total++; if (l1 !== 2) $display("FAIL lsr1_lat got %0d want 2", l1); else n_pass++;
        n_total++; if (cout1 !== c_carry_en) $display("FAIL lsr1_carry got %b want %b", cout1, c_carry_en); else n_pass++;
        n_total++; if (cout4 !== c_carry_en) $display("FAIL lsr1_carry4 got %b want %b", cout4, c_carry_en); else n_pass++;
        carry_in = 1'b1;
        do_op(1'b0, 1'b0, 12'h000, 32'h0000_0000, l1, l4, b1, r1, r4);
        carry_in = 1'b0;
        n_total++; if (cout1 !== c_carry_en) $display("FAIL cnt0_carry got %b want %b", cout1, c_carry_en); else n_pass++;
        do_op(1'b0, 1'b0, 12'h080, 32'h8000_0000, l1, l4, b1, r1, r4);
        n_total++; if (r1 !== 32'h0) $display("FAIL lsl1_res got %h want 00000000", r1); else n_pass++;
        n_total++; if (cout1 !== c_carry_en) $display("FAIL lsl1_carry got %b want %b", cout1, c_carry_en); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        rm = 32'h0000_0001; op = 12'h200; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (busy1 !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy1); else n_pass++;
        n_total++; if (result1 !== 32'h0) $display("FAIL rst_mid_result got %h want 0", result1); else n_pass++;
        n_total++; if (cout1 !== 1'b0) $display("FAIL rst_mid_carry got %b want 0", cout1); else n_pass++;
        n_total++; if (ready1 !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", ready1); else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done1 || done4) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rst_mid_done got %0d pulses want 0", seen); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; mem_en = 1'b0; imm = 1'b0;
        op = '0; rm = '0; carry_in = 1'b0;
        test_reset();
        test_lsl();
        test_imm_ror();
        test_asr31();
        test_zero_count();
        test_mem();
        test_flush();
        test_busy_start();
        test_start_flush();
        test_carry();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle iterative operand-2 unit for the EXE stage. It replaces the single-cycle combinational barrel shift/rotate with a controller that applies at most STEP bit positions per clock.
- Takes the same decode fields as the operand-2 path (mem_en, I, shifter_operand, val_Rm) and produces val2 with a start/done handshake.
- Drives `busy` to the hazard unit so the pipeline stalls while a shift is in flight.

Parameters:
- STEP, 1, maximum bit positions shifted per cycle; legal range 1..31.
- CNT_W, 5, width of the remaining-shift counter; fixed, covers shift amounts 0..31.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- flush  in  1  synchronous abort (branch taken / pipeline flush).
- mem_en  in  1  memory command: offset = sign-extended 12-bit value.
- imm  in  1  I bit: 32-bit rotated immediate.
- shifter_operand  in  12  operand field from the instruction.
- val_Rm  in  32  register operand.
- carry_in  in  1  current C flag.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result valid in this cycle.
- result  out  32  val2; holds its value until the next accepted start.
- carry_out  out  1  shifter carry (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, done=0, busy=0, carry_out=0, counter=0. A reset mid-operation discards the operation; no done is produced.
- States:
  - IDLE -> SHIFT when start=1 and the loaded count is nonzero.
  - IDLE -> DONE when start=1 and the loaded count is zero.
  - SHIFT -> SHIFT while count remains; SHIFT -> DONE when the count reaches 0.
  - DONE -> IDLE unconditionally.
- Load in IDLE when start=1, by priority:
  - mem_en=1: result={{20{op[11]}},op[11:0]}; count=0.
  - imm=1: acc={24'd0,op[7:0]}; type=ROR; count={op[11:8],1'b0}.
  - Otherwise: acc=val_Rm; type=op[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); count=op[11:7].
- SHIFT: each cycle k=min(STEP,count); acc is shifted by k using the latched type; count-=k.
  - LSL and LSR fill with zeros.
  - ASR replicates acc[31].
  - ROR rotates right.
- Latency: start in cycle 0 -> done high in cycle 1+ceil(count/STEP). Count 0 (including mem_en) gives latency 1.
- result updates only on load (mem_en) or on the last SHIFT step. It is stable in DONE and IDLE.
- start while ready=0 is ignored; there is no queueing. The requester must hold start until it sees ready.
- flush=1 in any state: next state IDLE, no done, result unchanged.
- flush and start in the same cycle: flush wins and the start is dropped.
- Shift amount 0 with type LSR/ASR/ROR: result=val_Rm, with no RRX/#32 special-casing.

Optional Feature:
- Macro: SHIFT_CARRY_OUT_EN.
- Defined:
  - carry_out = last bit shifted out: acc[32-k] for LSL, acc[k-1] for LSR/ASR/ROR.
  - The value is updated on every SHIFT step.
  - For count 0 or mem_en, carry_out=carry_in, latched at load.
- Undefined: carry_out is constantly 0 and carry_in is unused. The ports remain present in both builds.

Decomposition:
- Package shift_pkg holds:
  - shift-type constants LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11;
  - state encoding IDLE/SHIFT/DONE;
  - the localparam for the 32-bit data width.
- One combinational sub-module, shift_step: inputs acc, type, k (0..STEP); outputs the shifted value and the carry bit. The controller FSM and counter stay in shift_sequencer.

Test Plan:
- STEP=1, val_Rm=0x00000001, op=0x200 (LSL #4), start cycle 0 -> done in cycle 5, result=0x00000010, busy high cycles 1-5.
- STEP=1, imm=1, op=0x1FF (imm8 0xFF, rot 1) -> ROR 2, done in cycle 3, result=0xC000003F.
- ASR #31 of val_Rm=0x80000000 (op=0xFC0):
  - STEP=1 -> done in cycle 32;
  - STEP=4 -> done in cycle 9;
  - result=0xFFFFFFFF in both cases.
- mem_en=1, op=0x800 -> done in cycle 1, result=0xFFFFF800; same with op=0x7FF -> result=0x000007FF.
- Flush and overlapping start:
  - flush in cycle 2 of LSR #8 -> IDLE in cycle 3, no done pulse, result unchanged;
  - start asserted during busy -> ignored;
  - start with flush in the same cycle -> no operation.
- Reset and carry:
  - rst asserted mid-SHIFT -> all outputs 0 immediately.
  - With SHIFT_CARRY_OUT_EN: LSR #1 of 0x00000003 -> result=0x00000001, carry_out=1.
  - Without the macro: same operation gives carry_out=0.
